// File: rtl/reset_release_sequencer_pkg.sv
// Shared types and elaboration-time helpers for the reset release sequencer.
package reset_release_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_HOLD,
        ST_WAIT,
        ST_STEP,
        ST_DONE
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Wide enough to hold the largest reload value of the shared down-counter.
    function automatic int cnt_width(input int hold, input int step, input int tmo);
        return $clog2(max3(hold, step, tmo) + 1);
    endfunction

    function automatic int idx_width(input int num_domains);
        return (num_domains <= 1) ? 1 : $clog2(num_domains);
    endfunction

    function automatic bit params_legal(input int sync_stages, input int num_domains,
                                        input int hold, input int step, input int tmo);
        return (sync_stages >= 2) && (sync_stages <= 4) &&
               (num_domains >= 1) && (num_domains <= 16) &&
               (hold >= 1) && (step >= 1) && (tmo >= 1);
    endfunction

endpackage

// File: rtl/reset_release_sequencer_sync_chain.sv
// Reset synchronizer: asserts asynchronously, deasserts after SYNC_STAGES clock edges.
module reset_sync_chain #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    output logic synced
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Holds reset after power-on, then releases reset domains one by one in index order,
// waiting for each domain's ack (or a timeout) before moving on to the next.
module reset_release_sequencer
    import reset_release_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_rst_req,
    input  logic [NUM_DOMAINS-1:0] domain_ack,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   all_released,
    output logic                   busy,
    output logic [NUM_DOMAINS-1:0] timeout_err
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES, ACK_TIMEOUT);
    localparam int IDX_W = idx_width(NUM_DOMAINS);

    localparam logic [CNT_W-1:0]       HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       STEP_LOAD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]       TMO_LOAD  = CNT_W'(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] BIT0      = NUM_DOMAINS'(1);

    if (!params_legal(SYNC_STAGES, NUM_DOMAINS, HOLD_CYCLES, STEP_CYCLES, ACK_TIMEOUT)) begin : g_bad_params
        $error("reset_release_sequencer: illegal parameter combination");
    end

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_DOMAINS-1:0] rst_out_q;
    logic                   all_released_q;
    logic                   busy_q;
    logic [NUM_DOMAINS-1:0] timeout_err_q;

    logic                   synced;
    logic                   ack_sel;
    logic [IDX_W-1:0]       idx_inc;

    reset_sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .synced(synced)
    );

    assign ack_sel = domain_ack[idx_q];
    assign idx_inc = idx_q + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_SYNC;
            cnt_q          <= '0;
            idx_q          <= '0;
            rst_out_q      <= '1;
            all_released_q <= 1'b0;
            busy_q         <= 1'b1;
            timeout_err_q  <= '0;
        end else if (sw_rst_req && (state_q != ST_SYNC)) begin
            // Software re-request restarts the hold; error history survives.
            state_q        <= ST_HOLD;
            cnt_q          <= HOLD_LOAD;
            idx_q          <= '0;
            rst_out_q      <= '1;
            all_released_q <= 1'b0;
            busy_q         <= 1'b1;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (synced) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        rst_out_q[0] <= 1'b0;
                        idx_q        <= '0;
                        state_q      <= ST_WAIT;
                        cnt_q        <= TMO_LOAD;
                    end
                end
                ST_WAIT: begin
                    // An ack on the final timeout cycle counts as a normal ack.
                    if (ack_sel || (cnt_q == '0)) begin
                        if (!ack_sel) begin
                            timeout_err_q[idx_q] <= 1'b1;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q        <= ST_DONE;
                            all_released_q <= 1'b1;
                            busy_q         <= 1'b0;
                        end else begin
                            state_q <= ST_STEP;
                            cnt_q   <= STEP_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_STEP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        idx_q     <= idx_inc;
                        rst_out_q <= rst_out_q & ~(BIT0 << idx_inc);
                        state_q   <= ST_WAIT;
                        cnt_q     <= TMO_LOAD;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_q <= ST_SYNC;
                end
            endcase
        end
    end

    assign rst_out      = rst_out_q;
    assign all_released = all_released_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: fixed vectors, directed corner cases, and
// randomized ack latencies checked against an edge-time model of the release schedule.
module tb_reset_release_sequencer;

  localparam int ND  = 4;
  localparam int S   = 3;
  localparam int H   = 16;
  localparam int STP = 8;
  localparam int T   = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          sw_rst_req;
  logic [ND-1:0] domain_ack;
  logic [ND-1:0] rst_out;
  logic          all_released;
  logic          busy;
  logic [ND-1:0] timeout_err;

  logic       rst_n1;
  logic       sw1;
  logic [0:0] ack1;
  logic [0:0] rst_out1;
  logic       all1;
  logic       busy1;
  logic [0:0] terr1;

  reset_release_sequencer #(
    .SYNC_STAGES(S), .NUM_DOMAINS(ND), .HOLD_CYCLES(H),
    .STEP_CYCLES(STP), .ACK_TIMEOUT(T)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .domain_ack(domain_ack),
    .rst_out(rst_out), .all_released(all_released), .busy(busy), .timeout_err(timeout_err)
  );

  reset_release_sequencer #(
    .SYNC_STAGES(2), .NUM_DOMAINS(1), .HOLD_CYCLES(1),
    .STEP_CYCLES(8), .ACK_TIMEOUT(4)
  ) u_dut_small (
    .clk(clk), .rst_n(rst_n1), .sw_rst_req(sw1), .domain_ack(ack1),
    .rst_out(rst_out1), .all_released(all1), .busy(busy1), .timeout_err(terr1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  logic [ND-1:0] model_terr = '0;

  typedef int kvec_t [ND];

  typedef struct {
    int          edge_n;
    logic [ND-1:0] ack;
    logic [ND-1:0] rst;
    logic          all;
    logic          busy;
    logic [ND-1:0] terr;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic check_all(input logic [ND-1:0] e_rst, input logic e_all,
                           input logic e_busy, input logic [ND-1:0] e_terr);
    check("rst_out", 32'(rst_out), 32'(e_rst));
    check("all_released", 32'(all_released), 32'(e_all));
    check("busy", 32'(busy), 32'(e_busy));
    check("timeout_err", 32'(timeout_err), 32'(e_terr));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  // 1-unit low pulse between edges; outputs must react without a clock edge.
  task automatic pulse_rst_n();
    rst_n = 1'b0;
    #1;
    edge_n = 0;
    check_all('1, 1'b0, 1'b1, '0);
    rst_n = 1'b1;
  endtask

  // Reference model: release edge r[i] and accept edge e[i] from plain arithmetic.
  // k[i] is the edge offset after r[i] at which ack[i] is first sampled high.
  task automatic run_seq(input kvec_t k, input bit noise, input int stop_edge,
                         input bit use_sw, input int sw_len);
    int r [ND];
    int e [ND];
    bit err [ND];
    int entry;
    int last;
    logic [ND-1:0] terr_prev;
    logic [ND-1:0] er;
    logic [ND-1:0] et;
    logic ea;
    terr_prev = use_sw ? model_terr : '0;
    et = terr_prev;
    if (use_sw) edge_n = 0;
    else pulse_rst_n();
    entry = use_sw ? sw_len : S + 1;
    for (int i = 0; i < ND; i++) begin
      r[i] = (i == 0) ? entry + H : e[i-1] + STP;
      if (k[i] <= T + 1) begin
        e[i] = r[i] + k[i];
        err[i] = 1'b0;
      end else begin
        e[i] = r[i] + T + 1;
        err[i] = 1'b1;
      end
    end
    last = (stop_edge > 0) ? stop_edge : e[ND-1] + 2;
    for (int n = 1; n <= last; n++) begin
      if (use_sw) sw_rst_req = (n <= sw_len);
      else if (noise && n <= S + 1) sw_rst_req = 1'($urandom_range(0, 1));
      else sw_rst_req = 1'b0;
      for (int i = 0; i < ND; i++) begin
        if (k[i] <= T + 1 && n >= r[i] + k[i]) domain_ack[i] = 1'b1;
        else if (noise && n <= r[i]) domain_ack[i] = 1'($urandom_range(0, 1));
        else domain_ack[i] = 1'b0;
      end
      tick();
      for (int i = 0; i < ND; i++) begin
        er[i] = (n < r[i]);
        et[i] = terr_prev[i] | (err[i] && n >= e[i]);
      end
      ea = (n >= e[ND-1]);
      check_all(er, ea, !ea, et);
    end
    sw_rst_req = 1'b0;
    model_terr = et;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    kvec_t k;
    bit mode;
    tbl[0]  = '{3,  4'hF, 4'hF, 1'b0, 1'b1, 4'h0};
    tbl[1]  = '{19, 4'hF, 4'hF, 1'b0, 1'b1, 4'h0};
    tbl[2]  = '{20, 4'hF, 4'hE, 1'b0, 1'b1, 4'h0};
    tbl[3]  = '{28, 4'hF, 4'hE, 1'b0, 1'b1, 4'h0};
    tbl[4]  = '{29, 4'hF, 4'hC, 1'b0, 1'b1, 4'h0};
    tbl[5]  = '{37, 4'hF, 4'hC, 1'b0, 1'b1, 4'h0};
    tbl[6]  = '{38, 4'hF, 4'h8, 1'b0, 1'b1, 4'h0};
    tbl[7]  = '{46, 4'hF, 4'h8, 1'b0, 1'b1, 4'h0};
    tbl[8]  = '{47, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0};
    tbl[9]  = '{48, 4'hF, 4'h0, 1'b1, 1'b0, 4'h0};
    tbl[10] = '{60, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0};

    rst_n = 1'b0; sw_rst_req = 1'b0; domain_ack = '0;
    rst_n1 = 1'b0; sw1 = 1'b0; ack1 = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal release timing with every ack tied high.
    domain_ack = '1;
    pulse_rst_n();
    for (int v = 0; v < 11; v++) begin
      while (edge_n < tbl[v].edge_n) begin
        domain_ack = tbl[v].ack;
        tick();
      end
      check_all(tbl[v].rst, tbl[v].all, tbl[v].busy, tbl[v].terr);
    end

    // Domain 1 never acks: timeout flagged, sequence continues.
    run_seq('{1, 1000, 1, 1}, 1'b0, 0, 1'b0, 0);
    // One-cycle software request in DONE; error bit retained.
    run_seq('{1, 1, 1, 1}, 1'b0, 0, 1'b1, 1);
    // Software request held several cycles, with ignored ack noise.
    run_seq('{3, 2, 5, 1}, 1'b1, 0, 1'b1, 5);
    // Ack arrives on the very edge the timeout would fire; rst_n clears the old error.
    run_seq('{T + 1, 1, 1, 1}, 1'b0, 0, 1'b0, 0);
    // Interrupt mid-WAIT with a short rst_n pulse, then a full restart.
    run_seq('{100, 1, 1, 1}, 1'b0, 50, 1'b0, 0);
    run_seq('{1, 1, 1, 1}, 1'b1, 0, 1'b0, 0);

    // Randomized ack latencies, timeouts and restart sources.
    repeat (6) begin
      for (int i = 0; i < ND; i++) begin
        case ($urandom_range(0, 5))
          0:       k[i] = T + 2 + int'($urandom_range(0, 50));
          1:       k[i] = T + 1;
          default: k[i] = int'($urandom_range(1, 30));
        endcase
      end
      mode = 1'($urandom_range(0, 1));
      run_seq(k, 1'b1, 0, mode, int'($urandom_range(1, 4)));
    end

    // Single-domain instance: SYNC_STAGES=2, HOLD_CYCLES=1, ACK_TIMEOUT=4.
    rst_n1 = 1'b0;
    #1;
    edge_n = 0;
    check("small_rst_out_async", 32'(rst_out1), 32'd1);
    check("small_busy_async", 32'(busy1), 32'd1);
    rst_n1 = 1'b1;
    ack1 = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      check("small_rst_out", 32'(rst_out1), 32'(n < 4));
      check("small_all_released", 32'(all1), 32'(n >= 5));
      check("small_busy", 32'(busy1), 32'(n < 5));
    end
    rst_n1 = 1'b0;
    #1;
    edge_n = 0;
    rst_n1 = 1'b1;
    ack1 = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      tick();
      check("small_to_rst_out", 32'(rst_out1), 32'(n < 4));
      check("small_to_err", 32'(terr1), 32'(n >= 9));
      check("small_to_all", 32'(all1), 32'(n >= 9));
    end
    sw1 = 1'b1;
    tick();
    check("small_sw_rst_out", 32'(rst_out1), 32'd1);
    check("small_sw_err_kept", 32'(terr1), 32'd1);
    sw1 = 1'b0;
    ack1 = 1'b1;
    tick();
    check("small_sw_release", 32'(rst_out1), 32'd0);
    check("small_sw_all_low", 32'(all1), 32'd0);
    tick();
    check("small_sw_done", 32'(all1), 32'd1);
    check("small_sw_err_final", 32'(terr1), 32'd1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
